bird_physics: RTL and testbench

Parametrised vertical-motion engine for the player sprite, the successor to the fixed-constant bird block. It integrates velocity and position on an internally divided physics tick. Jumps are taken on the rising edge of `jump` and gravity is selectable. Velocity saturates independently upward and downward, and floor/ceiling contacts are reported to the game controller as pulses. It sits between the input debouncer and the collision and renderer blocks.

---
 rtl/flappy_pkg.sv | 21 ++
 rtl/tick_divider.sv | 36 +++
 rtl/bird_physics.sv | 158 +++++++++++++++
 tb/tb_bird_physics.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the flappy game blocks.
//   - Game state encodings driven by the game controller (2 bits).
//   - Screen-space constants used as defaults for the bird motion engine.
// No ports; imported by bird_physics and its neighbours.
// ---------------------------------------------------------------------------
package flappy_pkg;

   // Game state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_PLAY  = 2'd2;
   localparam logic [1:0] ST_OVER  = 2'd3;

   // Vertical screen geometry (+y is up)
   localparam int SCREEN_Y_MIN   = 0;
   localparam int SCREEN_Y_MAX   = 484;
   localparam int SCREEN_Y_START = 300;

endpackage

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Free-running modulo-DIV counter that flags the last count of each period.
// Shared by the bird physics engine and the pipe scroller.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset (counter restarts at 0)
//   tick out  high for one clock while the count equals DIV-1
// ---------------------------------------------------------------------------
module tick_divider #(
   parameter int DIV = 32
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (count_reg == LAST) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Decoded from the registered count, so tick is low while in reset.
   assign tick = (count_reg == LAST);

endmodule

// File: rtl/bird_physics.sv
// ---------------------------------------------------------------------------
// bird_physics
// Vertical-motion engine for the player sprite. Integrates signed velocity
// and position once per physics tick while in PLAY, with rising-edge jumps,
// selectable gravity, asymmetric velocity saturation and floor/ceiling
// clamping reported as one-clock pulses.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   enable       in   physics enable; low freezes PLAY
//   state        in   game state (IDLE/READY/PLAY/OVER)
//   jump         in   debounced jump level
//   fall_accel   in   gravity per tick, unsigned 0..3
//   y_coord      out  signed position, +y up
//   vel          out  signed velocity
//   tick         out  physics tick pulse
//   hit_floor    out  pulse when y is clamped to the floor
//   hit_ceiling  out  pulse when y is clamped to the ceiling
// ---------------------------------------------------------------------------
module bird_physics
   import flappy_pkg::*;
#(
   parameter int Y_W          = 11,
   parameter int VEL_W        = 8,
   parameter int TICK_DIV     = 32,
   parameter int Y_MIN        = SCREEN_Y_MIN,
   parameter int Y_MAX        = SCREEN_Y_MAX,
   parameter int Y_START      = SCREEN_Y_START,
   parameter int JUMP_IMPULSE = 10,
   parameter int VEL_UP_MAX   = 8,
   parameter int VEL_DN_MAX   = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [1:0]              state,
   input  logic                    jump,
   input  logic [1:0]              fall_accel,
   output logic signed [Y_W-1:0]   y_coord,
   output logic signed [VEL_W-1:0] vel,
   output logic                    tick,
   output logic                    hit_floor,
   output logic                    hit_ceiling
);

   // Velocity math is one bit wider than vel so the sums cannot wrap.
   localparam logic signed [VEL_W:0] IMPULSE = (VEL_W+1)'(JUMP_IMPULSE);
   localparam logic signed [VEL_W:0] UP_LIM  = (VEL_W+1)'(VEL_UP_MAX);
   localparam logic signed [VEL_W:0] DN_LIM  = (VEL_W+1)'(-VEL_DN_MAX);
   // Position math is one bit wider than y so y+vel cannot wrap.
   localparam logic signed [Y_W:0]   Y_LO    = (Y_W+1)'(Y_MIN);
   localparam logic signed [Y_W:0]   Y_HI    = (Y_W+1)'(Y_MAX);
   localparam logic signed [Y_W:0]   Y_SPAWN = (Y_W+1)'(Y_START);

   logic signed [Y_W-1:0]   y_reg;
   logic signed [VEL_W-1:0] vel_reg;
   logic                    jump_q_reg;
   logic                    jump_pend_reg;
   logic                    hit_floor_reg;
   logic                    hit_ceiling_reg;
   logic                    phys_tick;
   logic                    jump_rise;

   logic signed [VEL_W:0]   vel_ext;
   logic signed [VEL_W:0]   accel_ext;
   logic signed [VEL_W:0]   vel_jump;
   logic signed [VEL_W:0]   vel_fall;
   logic signed [VEL_W-1:0] vel_next;
   logic signed [Y_W:0]     y_ext;
   logic signed [Y_W:0]     vel_y;
   logic signed [Y_W:0]     y_next;

   tick_divider #(
      .DIV (TICK_DIV)
   ) u_tick_divider (
      .clk  (clk),
      .rst  (rst),
      .tick (phys_tick)
   );

   assign jump_rise = jump & ~jump_q_reg;

   always_comb begin
      vel_ext   = {vel_reg[VEL_W-1], vel_reg};
      accel_ext = {{(VEL_W-1){1'b0}}, fall_accel};
      vel_jump  = vel_ext + IMPULSE;
      vel_fall  = vel_ext - accel_ext;
      vel_next  = vel_reg;
      if (jump_pend_reg) begin
         vel_next = (vel_jump > UP_LIM) ? UP_LIM[VEL_W-1:0] : vel_jump[VEL_W-1:0];
      end else begin
         vel_next = (vel_fall < DN_LIM) ? DN_LIM[VEL_W-1:0] : vel_fall[VEL_W-1:0];
      end
      // Position advances with the velocity held before this tick.
      y_ext  = {y_reg[Y_W-1], y_reg};
      vel_y  = {{(Y_W+1-VEL_W){vel_reg[VEL_W-1]}}, vel_reg};
      y_next = y_ext + vel_y;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_reg           <= Y_LO[Y_W-1:0];
         vel_reg         <= '0;
         jump_q_reg      <= 1'b0;
         jump_pend_reg   <= 1'b0;
         hit_floor_reg   <= 1'b0;
         hit_ceiling_reg <= 1'b0;
      end else begin
         jump_q_reg      <= jump;
         hit_floor_reg   <= 1'b0;
         hit_ceiling_reg <= 1'b0;
         case (state)
            ST_IDLE: begin
               y_reg         <= Y_LO[Y_W-1:0];
               vel_reg       <= '0;
               jump_pend_reg <= 1'b0;
            end
            ST_READY: begin
               y_reg         <= Y_SPAWN[Y_W-1:0];
               vel_reg       <= '0;
               jump_pend_reg <= 1'b0;
            end
            ST_PLAY: begin
               if (enable && phys_tick) begin
                  // The pending jump is consumed here; a rise in this very
                  // cycle is kept for the following tick.
                  jump_pend_reg <= jump_rise;
                  if (y_next <= Y_LO) begin
                     y_reg         <= Y_LO[Y_W-1:0];
                     vel_reg       <= '0;
                     hit_floor_reg <= 1'b1;
                  end else if (y_next >= Y_HI) begin
                     y_reg           <= Y_HI[Y_W-1:0];
                     vel_reg         <= '0;
                     hit_ceiling_reg <= 1'b1;
                  end else begin
                     y_reg   <= y_next[Y_W-1:0];
                     vel_reg <= vel_next;
                  end
               end else if (jump_rise) begin
                  jump_pend_reg <= 1'b1;
               end
            end
            default: begin
               // OVER: motion frozen, no jump carried into the next round.
               jump_pend_reg <= 1'b0;
            end
         endcase
      end
   end

   assign y_coord     = y_reg;
   assign vel         = vel_reg;
   assign tick        = phys_tick;
   assign hit_floor   = hit_floor_reg;
   assign hit_ceiling = hit_ceiling_reg;

endmodule

// File: tb/tb_bird_physics.sv
// ---------------------------------------------------------------------------
// tb_bird_physics
// Self-checking bench for bird_physics with a short tick period. Expected
// position/velocity records are queued when stimulus is applied and popped
// and compared after the physics update edge.
// ---------------------------------------------------------------------------
module tb_bird_physics;

   localparam int TICK_DIV = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [1:0]        state;
   logic              jump;
   logic [1:0]        fall_accel;
   logic signed [10:0] y_coord;
   logic signed [7:0] vel;
   logic              tick;
   logic              hit_floor;
   logic              hit_ceiling;

   bird_physics #(
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .state       (state),
      .jump        (jump),
      .fall_accel  (fall_accel),
      .y_coord     (y_coord),
      .vel         (vel),
      .tick        (tick),
      .hit_floor   (hit_floor),
      .hit_ceiling (hit_ceiling)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      int v;
      bit hf;
      bit hc;
   } exp_t;

   typedef struct {
      logic [1:0] st;
      bit         en;
      int         rises;
      logic [1:0] fa;
      int         y;
      int         v;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[14];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance to the cycle where tick is high, then through the update edge.
   task automatic wait_tick_end(input string name);
      int n;
      n = 0;
      while (!tick && n < 4 * TICK_DIV) begin
         step();
         n++;
      end
      check({name, "_tick_seen"}, int'(tick), 1);
      step();
   endtask

   task automatic pulse_jumps(input int n);
      for (int i = 0; i < n; i++) begin
         jump = 1'b1;
         step();
         jump = 1'b0;
         step();
      end
   endtask

   task automatic push_exp(input int y, input int v, input bit hf, input bit hc);
      exp_t e;
      e.y  = y;
      e.v  = v;
      e.hf = hf;
      e.hc = hc;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({name, "_queue"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         $display("txn %s: y=%0d vel=%0d hf=%0b hc=%0b (exp y=%0d vel=%0d hf=%0b hc=%0b)",
                  name, y_coord, vel, hit_floor, hit_ceiling, e.y, e.v, e.hf, e.hc);
         check({name, "_y"}, int'(y_coord), e.y);
         check({name, "_vel"}, int'(vel), e.v);
         check({name, "_hit_floor"}, int'(hit_floor), int'(e.hf));
         check({name, "_hit_ceiling"}, int'(hit_ceiling), int'(e.hc));
      end
   endtask

   initial begin
      int  ey, ev, ny, nv, n;
      bit  hit;

      // Free fall from spawn, triple-rise jump, gravity variants, clipped jump.
      vecs[0]  = '{2'd2, 1'b1, 0, 2'd1, 300, -1};
      vecs[1]  = '{2'd2, 1'b1, 0, 2'd1, 299, -2};
      vecs[2]  = '{2'd2, 1'b1, 0, 2'd1, 297, -3};
      vecs[3]  = '{2'd2, 1'b1, 0, 2'd1, 294, -4};
      vecs[4]  = '{2'd2, 1'b1, 0, 2'd1, 290, -5};
      vecs[5]  = '{2'd2, 1'b1, 0, 2'd1, 285, -5};
      vecs[6]  = '{2'd2, 1'b1, 0, 2'd1, 280, -5};
      vecs[7]  = '{2'd2, 1'b1, 3, 2'd1, 275,  5};
      vecs[8]  = '{2'd2, 1'b1, 0, 2'd1, 280,  4};
      vecs[9]  = '{2'd2, 1'b1, 0, 2'd0, 284,  4};
      vecs[10] = '{2'd2, 1'b1, 0, 2'd3, 288,  1};
      vecs[11] = '{2'd2, 1'b1, 0, 2'd1, 289,  0};
      vecs[12] = '{2'd2, 1'b1, 1, 2'd1, 289,  8};
      vecs[13] = '{2'd2, 1'b1, 0, 2'd0, 297,  8};

      rst        = 1'b1;
      enable     = 1'b1;
      state      = 2'd0;
      jump       = 1'b0;
      fall_accel = 2'd0;
      step();
      step();
      check("reset_y", int'(y_coord), 0);
      check("reset_vel", int'(vel), 0);
      check("reset_tick", int'(tick), 0);
      check("reset_hit_floor", int'(hit_floor), 0);
      check("reset_hit_ceiling", int'(hit_ceiling), 0);
      rst = 1'b0;

      state = 2'd1;
      step();
      check("ready_y", int'(y_coord), 300);
      check("ready_vel", int'(vel), 0);

      for (int i = 0; i < 14; i++) begin
         state      = vecs[i].st;
         enable     = vecs[i].en;
         fall_accel = vecs[i].fa;
         push_exp(vecs[i].y, vecs[i].v, 1'b0, 1'b0);
         pulse_jumps(vecs[i].rises);
         wait_tick_end($sformatf("vec%0d", i));
         pop_check($sformatf("vec%0d", i));
      end

      // Climb at constant velocity until the ceiling clamp.
      ey = 297;
      fall_accel = 2'd0;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         ny = ey + 8;
         if (ny >= 484) begin
            push_exp(484, 0, 1'b0, 1'b1);
            hit = 1'b1;
         end else begin
            push_exp(ny, 8, 1'b0, 1'b0);
            ey = ny;
         end
         wait_tick_end("climb");
         pop_check("climb");
      end
      check("ceiling_reached", int'(hit), 1);
      step();
      check("ceiling_pulse_one_clock", int'(hit_ceiling), 0);

      // Respawn, then a jump rise inside the tick cycle is deferred a tick.
      state = 2'd1;
      step();
      check("respawn_y", int'(y_coord), 300);
      state      = 2'd2;
      fall_accel = 2'd1;
      n = 0;
      while (!tick && n < 4 * TICK_DIV) begin
         step();
         n++;
      end
      check("tickcycle_tick_seen", int'(tick), 1);
      jump = 1'b1;
      push_exp(300, -1, 1'b0, 1'b0);
      step();
      pop_check("tickcycle_jump_deferred");
      jump = 1'b0;
      push_exp(299, 8, 1'b0, 1'b0);
      wait_tick_end("tickcycle_jump_applied");
      pop_check("tickcycle_jump_applied");

      // Freeze with a jump pending; it must survive and apply afterwards.
      pulse_jumps(1);
      enable     = 1'b0;
      fall_accel = 2'd2;
      for (int i = 0; i < 3; i++) begin
         push_exp(299, 8, 1'b0, 1'b0);
         wait_tick_end("freeze");
         pop_check("freeze");
      end
      enable = 1'b1;
      push_exp(307, 8, 1'b0, 1'b0);
      wait_tick_end("unfreeze_pending_jump");
      pop_check("unfreeze_pending_jump");

      // OVER holds, and a rise seen in OVER is not carried into PLAY.
      state = 2'd3;
      push_exp(307, 8, 1'b0, 1'b0);
      wait_tick_end("over_hold");
      pop_check("over_hold");
      pulse_jumps(1);
      push_exp(307, 8, 1'b0, 1'b0);
      wait_tick_end("over_hold2");
      pop_check("over_hold2");
      state = 2'd2;
      push_exp(315, 6, 1'b0, 1'b0);
      wait_tick_end("play_after_over");
      pop_check("play_after_over");

      // Heavy gravity descent to the floor clamp.
      ey = 315;
      ev = 6;
      fall_accel = 2'd3;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         nv = (ev - 3 < -5) ? -5 : ev - 3;
         ny = ey + ev;
         if (ny <= 0) begin
            push_exp(0, 0, 1'b1, 1'b0);
            hit = 1'b1;
         end else begin
            push_exp(ny, nv, 1'b0, 1'b0);
            ey = ny;
            ev = nv;
         end
         wait_tick_end("fall");
         pop_check("fall");
      end
      check("floor_reached", int'(hit), 1);
      step();
      check("floor_pulse_one_clock", int'(hit_floor), 0);

      state = 2'd0;
      step();
      check("idle_y", int'(y_coord), 0);
      check("idle_vel", int'(vel), 0);

      // Reset in the middle of a tick period.
      state = 2'd1;
      step();
      state      = 2'd2;
      fall_accel = 2'd1;
      push_exp(300, -1, 1'b0, 1'b0);
      wait_tick_end("pre_reset");
      pop_check("pre_reset");
      step();
      step();
      step();
      rst = 1'b1;
      step();
      check("midrst_y", int'(y_coord), 0);
      check("midrst_vel", int'(vel), 0);
      check("midrst_tick", int'(tick), 0);
      check("midrst_hit_floor", int'(hit_floor), 0);
      rst   = 1'b0;
      state = 2'd0;
      n = 0;
      while (!tick && n < 100) begin
         step();
         n++;
      end
      check("first_tick_after_rst", n, TICK_DIV - 1);
      n = 0;
      step();
      n++;
      while (!tick && n < 100) begin
         step();
         n++;
      end
      check("tick_period", n, TICK_DIV);

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
